// File: rtl/mem_arb_pkg.sv
// mem_arbiter shared types
// state encodings and requester ids
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// two-way round-robin pick
// rr_last names the most recent winner
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr_last,
  output logic [1:0] gnt
);

  // a tie goes to whoever did not win last
  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (req == 2'b01): gnt = 2'b01;
      (req == 2'b10): gnt = 2'b10;
      (req == 2'b11): begin
        gnt = (rr_last == REQ_CPU) ?
              2'b10 : 2'b01;
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// single-port memory arbiter
// round-robin with lock and lock timeout
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 6,
  parameter int DATA_WIDTH   = 16,
  parameter int LOCK_TIMEOUT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic                  m0_lock,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic                  m1_lock,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_in,
  output logic                  lock_err
);

  localparam int HW =
    $clog2(LOCK_TIMEOUT) + 1;
  localparam logic [HW-1:0] HOLD_LAST =
    HW'(LOCK_TIMEOUT - 1);
  localparam logic [HW-1:0] HOLD_MAX =
    '1;

  state_t        state_q, state_d;
  logic          rr_q, rr_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          err_q, err_d;
  logic          rv0_q, rv1_q;
  logic [1:0]    pick;
  logic [1:0]    gnt;

  rr_arb2 u_rr (
    .req     ({m1_req, m0_req}),
    .rr_last (rr_q),
    .gnt     (pick)
  );

  // ownership, hold counter and grant
  always_comb begin
    gnt     = 2'b00;
    state_d = state_q;
    rr_d    = rr_q;
    hold_d  = hold_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        gnt    = pick;
        hold_d = '0;
        if (gnt[0]) rr_d = REQ_CPU;
        if (gnt[1]) rr_d = REQ_DBG;
        if (gnt[0] && m0_lock) begin
          state_d = OWN0;
          hold_d  = HW'(1);
        end else if (gnt[1] && m1_lock) begin
          state_d = OWN1;
          hold_d  = HW'(1);
        end
      end
      OWN0: begin
        gnt[0] = m0_req;
        if (!m0_lock) begin
          state_d = IDLE;
          hold_d  = '0;
        end else if (hold_q >= HOLD_LAST) begin
          state_d = IDLE;
          hold_d  = '0;
          err_d   = 1'b1;
          rr_d    = REQ_CPU;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + HW'(1);
        end
      end
      OWN1: begin
        gnt[1] = m1_req;
        if (!m1_lock) begin
          state_d = IDLE;
          hold_d  = '0;
        end else if (hold_q >= HOLD_LAST) begin
          state_d = IDLE;
          hold_d  = '0;
          err_d   = 1'b1;
          rr_d    = REQ_DBG;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
      end
    endcase
    // nothing reaches memory while in reset
    if (!rst_n) gnt = 2'b00;
  end

  // state, round-robin and error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= REQ_DBG;
      hold_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end
  end

  // read-valid follows a granted read by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rv0_q <= 1'b0;
      rv1_q <= 1'b0;
    end else begin
      rv0_q <= gnt[0] & ~m0_we;
      rv1_q <= gnt[1] & ~m1_we;
    end
  end

  // memory port mirrors the granted requester
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    if (gnt[0]) begin
      mem_we   = m0_we;
      mem_addr = m0_addr;
      mem_data = m0_wdata;
    end else if (gnt[1]) begin
      mem_we   = m1_we;
      mem_addr = m1_addr;
      mem_data = m1_wdata;
    end
  end

  assign m0_gnt    = gnt[0];
  assign m1_gnt    = gnt[1];
  assign m0_rvalid = rv0_q;
  assign m1_rvalid = rv1_q;
  assign m0_rdata  = rv0_q ? mem_in : '0;
  assign m1_rdata  = rv1_q ? mem_in : '0;
  assign lock_err  = err_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port program/data memory (ADDR_WIDTH address, DATA_WIDTH data, 1-cycle synchronous read) between two requesters.
- Requester 0 is the CPU core. Requester 1 is the loader/debug port.
- Arbitration is round-robin. A requester can hold a lock so that multi-cycle sequences (e.g. indirect load/store) run without interleaving.
- A lock timeout forces ownership release and raises a sticky error.

Parameters:
ADDR_WIDTH, 6, memory address width
DATA_WIDTH, 16, memory data width
LOCK_TIMEOUT, 8, max consecutive owned cycles before forced release (>=2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
m0_req  input  1  requester 0 access request
m0_we  input  1  requester 0 write enable (qualified by grant)
m0_lock  input  1  requester 0 keep-ownership request
m0_addr  input  ADDR_WIDTH  requester 0 address
m0_wdata  input  DATA_WIDTH  requester 0 write data
m0_gnt  output  1  requester 0 granted this cycle (combinational)
m0_rvalid  output  1  requester 0 read data valid (registered)
m0_rdata  output  DATA_WIDTH  requester 0 read data
m1_*  same set as m0_* for requester 1
mem_we  output  1  memory write enable
mem_addr  output  ADDR_WIDTH  memory address
mem_data  output  DATA_WIDTH  memory write data
mem_in  input  DATA_WIDTH  memory read data (valid cycle after address)
lock_err  output  1  sticky: a lock timed out

Behaviour:
- Clock and reset: one clock clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - state=IDLE, rr_last=1 (so requester 0 wins the first tie), hold_cnt=0.
  - m0_rvalid=m1_rvalid=0, lock_err=0.
  - Combinational outputs are 0 while no request is pending.
- States:
  - IDLE: no owner.
  - OWN0 / OWN1: requester holds a lock.
- Grant, IDLE state:
  - Single requester: granted in the same cycle.
  - Both requesting: grant goes to the requester that is not rr_last.
  - rr_last updates to the granted id at the clock edge.
- Grant, OWNi state:
  - Only requester i can be granted, and only while mi_req=1.
  - The other requester sees gnt=0 even if owner req=0. Memory is idle that cycle: mem_we=0, mem_addr=0, mem_data=0.
- Memory drive: mem_addr/mem_data mirror the granted requester; mem_we = gnt & we. With no grant, all are 0.
- Read latency:
  - A granted read (we=0) in cycle t gives mi_rvalid=1 in cycle t+1.
  - mi_rdata = mem_in, passed through combinationally, and is meaningful only while rvalid=1.
  - Writes never raise rvalid.
  - rdata of the non-valid requester is 0.
- Lock entry: granted in IDLE with mi_lock=1 → OWNi next cycle, hold_cnt=1. Lock without a grant is ignored.
- Lock release: in OWNi with mi_lock=0 → IDLE next cycle. An access in that release cycle is still granted to i.
- Timeout:
  - hold_cnt increments each cycle in OWNi.
  - When hold_cnt reaches LOCK_TIMEOUT-1 and the lock is still asserted: next state is IDLE, lock_err set (sticky until reset), rr_last=i, so the other requester wins the next tie.
  - The owner cannot re-lock in the cycle after a forced release if the other requester is pending.
- Simultaneous events:
  - An owner release and a pending other request in the same cycle: the other requester is granted in the next cycle, not the same one.
  - hold_cnt resets to 0 on entering IDLE.
- Reset mid-operation: a pending rvalid is dropped, ownership is lost, and no memory write is issued while rst_n=0.
- Widths: hold_cnt is clog2(LOCK_TIMEOUT)+1 bits and saturates (never wraps).

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encodings IDLE/OWN0/OWN1 (2-bit)
  - requester ids REQ_CPU=0, REQ_DBG=1
- Natural sub-module: rr_arb2, the combinational two-way round-robin pick from req and rr_last.
- State register, hold counter, rvalid pipeline and output muxing remain in mem_arbiter.

Test Plan:
- After reset, m0_req=1, we=0, addr=5, with mem[5]=0x1234 → m0_gnt=1 same cycle, mem_addr=5; next cycle m0_rvalid=1, m0_rdata=0x1234, m1_rvalid=0.
- Both requesters read every cycle (addr 1 and 2) → grants alternate 0,1,0,1; mem_addr sequence 1,2,1,2.
- m1 write (addr=7, data=0xBEEF) with m0 idle → mem_we=1, mem_addr=7, mem_data=0xBEEF in the same cycle; no rvalid on either port.
- m0 locks, reads addr 3, then idles one cycle, then writes addr 4 with lock dropped; m1_req held high throughout → m1_gnt=0 for all three cycles; m1 granted the cycle after release.
- m0 holds lock and req for 10 cycles with LOCK_TIMEOUT=8 and m1 pending → forced release after 8 owned cycles, lock_err=1 and stays 1; m1 granted next.
- rst_n pulsed low in the cycle after a granted m0 read → m0_rvalid=0, state IDLE, lock_err=0, mem_we=0 during reset.
